sfp_link_scheduler: RTL and testbench

- Sequences all transactions on the SFP master link: one software command path plus periodic status polling of up to 4 slave IDs, one transaction in flight at a time.
- Sits between the SFP AXI register block (software cmd/data/flag/id, response readback) and the SFP master transceiver.
- Issues cmd/data with a one-cycle flag pulse, waits for the response with a timeout, and routes the result to the requester.

---
 rtl/sfp_sched_pkg.sv | 17 +
 rtl/sfp_rr_pick.sv | 31 +++
 rtl/sfp_link_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_sfp_link_scheduler.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfp_sched_pkg.sv
// Shared definitions for the SFP link scheduler: FSM encoding, requester
// identifiers and the link response width.
package sfp_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3
  } sched_state_e;

  localparam logic OWNER_SW   = 1'b0;
  localparam logic OWNER_POLL = 1'b1;

  localparam int RSP_W = 64;

endpackage

// File: rtl/sfp_rr_pick.sv
// Round-robin selector: returns the first set mask bit at or after the
// pointer, wrapping around the four slave IDs.
module sfp_rr_pick (
  input  logic [3:0] i_mask,
  input  logic [1:0] i_ptr,
  output logic [1:0] o_id,
  output logic       o_valid
);

  logic [1:0] w_idx [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_idx
      assign w_idx[gi] = i_ptr + 2'(gi);
    end
  endgenerate

  // Scan from the farthest offset down so the closest candidate wins.
  always_comb begin
    o_id    = i_ptr;
    o_valid = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (i_mask[w_idx[k]]) begin
        o_id    = w_idx[k];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sfp_link_scheduler.sv
// Single-transaction sequencer for the SFP master link: software commands
// take priority over periodic round-robin status polls of up to 4 slaves.
module sfp_link_scheduler
  import sfp_sched_pkg::*;
#(
  parameter int                    DATA_WIDTH  = RSP_W / 2,
  parameter int                    POLL_PERIOD = 100000,
  parameter int                    RSP_TIMEOUT = 10000,
  parameter logic [DATA_WIDTH-1:0] POLL_CMD    = DATA_WIDTH'(32'h0000_0010)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_sw_req_flag,
  input  logic [1:0]              i_sw_id,
  input  logic [DATA_WIDTH-1:0]   i_sw_cmd,
  input  logic [DATA_WIDTH-1:0]   i_sw_data,
  output logic                    o_sw_busy,
  output logic                    o_sw_done,
  output logic                    o_sw_timeout,
  output logic [2*DATA_WIDTH-1:0] o_sw_rsp,
  input  logic                    i_poll_en,
  input  logic [3:0]              i_poll_mask,
  output logic                    o_poll_rsp_valid,
  output logic [1:0]              o_poll_id,
  output logic [2*DATA_WIDTH-1:0] o_poll_rsp,
  output logic [1:0]              o_sfp_id,
  output logic [DATA_WIDTH-1:0]   o_m_sfp_cmd,
  output logic [DATA_WIDTH-1:0]   o_m_sfp_data,
  output logic                    o_m_sfp_flag,
  input  logic [2*DATA_WIDTH-1:0] i_m_sfp_rsp,
  input  logic                    i_m_sfp_rsp_valid,
  output logic [15:0]             o_timeout_cnt,
  output logic [2:0]              o_state
);

  localparam logic [31:0] POLL_LAST = 32'(POLL_PERIOD - 1);
  // The done pulse lands RSP_TIMEOUT cycles after the issue strobe.
  localparam logic [31:0] WAIT_LAST = 32'((RSP_TIMEOUT > 2) ? RSP_TIMEOUT - 2 : 0);

  sched_state_e            r_state;
  logic                    r_owner;
  logic                    r_sw_pend;
  logic                    r_poll_pend;
  logic                    r_sw_flag_q;
  logic [1:0]              r_sw_id;
  logic [DATA_WIDTH-1:0]   r_sw_cmd;
  logic [DATA_WIDTH-1:0]   r_sw_data;
  logic [31:0]             r_poll_timer;
  logic [31:0]             r_wait_cnt;
  logic [1:0]              r_rr_ptr;
  logic [1:0]              r_sfp_id;
  logic [DATA_WIDTH-1:0]   r_m_cmd;
  logic [DATA_WIDTH-1:0]   r_m_data;
  logic                    r_m_flag;
  logic                    r_sw_done;
  logic                    r_sw_timeout;
  logic [2*DATA_WIDTH-1:0] r_sw_rsp;
  logic                    r_poll_valid;
  logic [1:0]              r_poll_id;
  logic [2*DATA_WIDTH-1:0] r_poll_rsp;
  logic [15:0]             r_timeout_cnt;

  logic                    w_sw_edge;
  logic                    w_sw_busy;
  logic                    w_poll_run;
  logic                    w_poll_tick;
  logic                    w_wait_end;
  logic                    w_wait_to;
  logic [2*DATA_WIDTH-1:0] w_done_rsp;
  logic [1:0]              w_pick_id;
  logic                    w_pick_valid;

  assign w_sw_edge   = i_sw_req_flag & ~r_sw_flag_q;
  assign w_sw_busy   = r_sw_pend | ((r_owner == OWNER_SW) && (r_state != ST_IDLE));
  assign w_poll_run  = i_en & i_poll_en & (|i_poll_mask);
  assign w_poll_tick = w_poll_run && (r_poll_timer == POLL_LAST);
  // A response arriving on the expiry cycle still wins over the timeout.
  assign w_wait_to   = ~i_m_sfp_rsp_valid;
  assign w_wait_end  = i_m_sfp_rsp_valid || (r_wait_cnt == WAIT_LAST);
  assign w_done_rsp  = i_m_sfp_rsp_valid ? i_m_sfp_rsp : '0;

  sfp_rr_pick u_rr_pick (
    .i_mask  (i_poll_mask),
    .i_ptr   (r_rr_ptr),
    .o_id    (w_pick_id),
    .o_valid (w_pick_valid)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sw_flag_q  <= 1'b0;
      r_poll_timer <= '0;
    end else begin
      r_sw_flag_q <= i_sw_req_flag;
      if (!w_poll_run || w_poll_tick) begin
        r_poll_timer <= '0;
      end else begin
        r_poll_timer <= r_poll_timer + 32'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= ST_IDLE;
      r_owner       <= OWNER_SW;
      r_sw_pend     <= 1'b0;
      r_poll_pend   <= 1'b0;
      r_sw_id       <= '0;
      r_sw_cmd      <= '0;
      r_sw_data     <= '0;
      r_wait_cnt    <= '0;
      r_rr_ptr      <= '0;
      r_sfp_id      <= '0;
      r_m_cmd       <= '0;
      r_m_data      <= '0;
      r_m_flag      <= 1'b0;
      r_sw_done     <= 1'b0;
      r_sw_timeout  <= 1'b0;
      r_sw_rsp      <= '0;
      r_poll_valid  <= 1'b0;
      r_poll_id     <= '0;
      r_poll_rsp    <= '0;
      r_timeout_cnt <= '0;
    end else begin
      r_m_flag     <= 1'b0;
      r_sw_done    <= 1'b0;
      r_poll_valid <= 1'b0;
      if (!i_en) begin
        r_state     <= ST_IDLE;
        r_sw_pend   <= 1'b0;
        r_poll_pend <= 1'b0;
      end else begin
        if (w_sw_edge && !w_sw_busy) begin
          r_sw_pend    <= 1'b1;
          r_sw_id      <= i_sw_id;
          r_sw_cmd     <= i_sw_cmd;
          r_sw_data    <= i_sw_data;
          r_sw_timeout <= 1'b0;
        end
        case (r_state)
          ST_IDLE: begin
            if (r_sw_pend) begin
              r_state  <= ST_ISSUE;
              r_owner  <= OWNER_SW;
              r_sfp_id <= r_sw_id;
              r_m_cmd  <= r_sw_cmd;
              r_m_data <= r_sw_data;
              r_m_flag <= 1'b1;
            end else if (r_poll_pend) begin
              r_poll_pend <= 1'b0;
              if (w_pick_valid) begin
                r_state  <= ST_ISSUE;
                r_owner  <= OWNER_POLL;
                r_sfp_id <= w_pick_id;
                r_m_cmd  <= POLL_CMD;
                r_m_data <= '0;
                r_m_flag <= 1'b1;
                r_rr_ptr <= w_pick_id + 2'd1;
              end
            end
          end
          ST_ISSUE: begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= '0;
          end
          ST_WAIT: begin
            if (w_wait_end) begin
              r_state <= ST_DONE;
              if (r_owner == OWNER_SW) begin
                r_sw_rsp     <= w_done_rsp;
                r_sw_done    <= 1'b1;
                r_sw_timeout <= w_wait_to;
              end else begin
                r_poll_rsp   <= w_done_rsp;
                r_poll_id    <= r_sfp_id;
                r_poll_valid <= 1'b1;
              end
              if (w_wait_to && (r_timeout_cnt != 16'hFFFF)) begin
                r_timeout_cnt <= r_timeout_cnt + 16'd1;
              end
            end else begin
              r_wait_cnt <= r_wait_cnt + 32'd1;
            end
          end
          ST_DONE: begin
            if (r_owner == OWNER_SW) begin
              r_sw_pend <= 1'b0;
            end
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
        // Ticks merge into a single pending poll; a fresh tick beats the clear.
        if (w_poll_tick) begin
          r_poll_pend <= 1'b1;
        end
      end
    end
  end

  assign o_sw_busy        = w_sw_busy;
  assign o_sw_done        = r_sw_done;
  assign o_sw_timeout     = r_sw_timeout;
  assign o_sw_rsp         = r_sw_rsp;
  assign o_poll_rsp_valid = r_poll_valid;
  assign o_poll_id        = r_poll_id;
  assign o_poll_rsp       = r_poll_rsp;
  assign o_sfp_id         = r_sfp_id;
  assign o_m_sfp_cmd      = r_m_cmd;
  assign o_m_sfp_data     = r_m_data;
  assign o_m_sfp_flag     = r_m_flag;
  assign o_timeout_cnt    = r_timeout_cnt;
  assign o_state          = r_state;

endmodule

// File: tb/tb_sfp_link_scheduler.sv
// Self-checking bench for sfp_link_scheduler: randomized software and poll
// traffic checked against a transaction-level timing and round-robin model.
module tb_sfp_link_scheduler;

  localparam int          DW   = 32;
  localparam int          PP   = 50;
  localparam int          TO   = 16;
  localparam logic [31:0] PCMD = 32'h0000_0010;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_en = 1'b0;
  logic          i_sw_req_flag = 1'b0;
  logic [1:0]    i_sw_id = '0;
  logic [DW-1:0] i_sw_cmd = '0;
  logic [DW-1:0] i_sw_data = '0;
  logic          o_sw_busy;
  logic          o_sw_done;
  logic          o_sw_timeout;
  logic [63:0]   o_sw_rsp;
  logic          i_poll_en = 1'b0;
  logic [3:0]    i_poll_mask = '0;
  logic          o_poll_rsp_valid;
  logic [1:0]    o_poll_id;
  logic [63:0]   o_poll_rsp;
  logic [1:0]    o_sfp_id;
  logic [DW-1:0] o_m_sfp_cmd;
  logic [DW-1:0] o_m_sfp_data;
  logic          o_m_sfp_flag;
  logic [63:0]   i_m_sfp_rsp = '0;
  logic          i_m_sfp_rsp_valid = 1'b0;
  logic [15:0]   o_timeout_cnt;
  logic [2:0]    o_state;

  int          checks = 0;
  int          errors = 0;
  int          m_tcnt = 0;
  int          m_ptr = 0;
  logic [63:0] m_sw_rsp = '0;

  sfp_link_scheduler #(
    .DATA_WIDTH  (DW),
    .POLL_PERIOD (PP),
    .RSP_TIMEOUT (TO),
    .POLL_CMD    (PCMD)
  ) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_en              (i_en),
    .i_sw_req_flag     (i_sw_req_flag),
    .i_sw_id           (i_sw_id),
    .i_sw_cmd          (i_sw_cmd),
    .i_sw_data         (i_sw_data),
    .o_sw_busy         (o_sw_busy),
    .o_sw_done         (o_sw_done),
    .o_sw_timeout      (o_sw_timeout),
    .o_sw_rsp          (o_sw_rsp),
    .i_poll_en         (i_poll_en),
    .i_poll_mask       (i_poll_mask),
    .o_poll_rsp_valid  (o_poll_rsp_valid),
    .o_poll_id         (o_poll_id),
    .o_poll_rsp        (o_poll_rsp),
    .o_sfp_id          (o_sfp_id),
    .o_m_sfp_cmd       (o_m_sfp_cmd),
    .o_m_sfp_data      (o_m_sfp_data),
    .o_m_sfp_flag      (o_m_sfp_flag),
    .i_m_sfp_rsp       (i_m_sfp_rsp),
    .i_m_sfp_rsp_valid (i_m_sfp_rsp_valid),
    .o_timeout_cnt     (o_timeout_cnt),
    .o_state           (o_state)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // First mask bit at or after ptr, wrapping; -1 when the mask is empty.
  function automatic int model_pick(logic [3:0] mask, int ptr);
    for (int k = 0; k < 4; k++) begin
      if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // One software transaction; the response is driven d cycles after the strobe.
  task automatic run_sw(input logic [1:0] id, input logic [31:0] cmd, input logic [31:0] data,
                        input logic [63:0] rsp, input int d, input string name);
    logic [63:0] exp_rsp;
    bit          exp_to;
    int          exp_cyc;
    int          cyc;
    bit          seen;
    // A response sampled no later than TO cycles after the strobe is accepted.
    exp_to  = (d + 1 > TO);
    exp_cyc = exp_to ? TO : d + 1;
    exp_rsp = exp_to ? 64'd0 : rsp;
    i_sw_id = id;
    i_sw_cmd = cmd;
    i_sw_data = data;
    i_sw_req_flag = 1'b1;
    step();
    checks++;
    if (o_m_sfp_flag !== 1'b0 || o_sw_busy !== 1'b1 || o_sw_timeout !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept: flag=%b busy=%b to=%b required flag=0 busy=1 to=0",
               name, o_m_sfp_flag, o_sw_busy, o_sw_timeout);
    end
    step();
    checks++;
    if (o_m_sfp_flag !== 1'b1 || o_sfp_id !== id || o_m_sfp_cmd !== cmd || o_m_sfp_data !== data) begin
      errors++;
      $display("FAIL %s_issue: flag=%b id=%0d cmd=%h data=%h required 1 %0d %h %h",
               name, o_m_sfp_flag, o_sfp_id, o_m_sfp_cmd, o_m_sfp_data, id, cmd, data);
    end
    i_sw_req_flag = 1'b0;
    cyc = 0;
    seen = 0;
    i_m_sfp_rsp = rsp;
    while (!seen && cyc < 60) begin
      i_m_sfp_rsp_valid = (cyc == d);
      step();
      cyc++;
      if (cyc == 1) begin
        checks++;
        if (o_m_sfp_flag !== 1'b0) begin
          errors++;
          $display("FAIL %s_flag_width: flag=%b one cycle after issue, required 0", name, o_m_sfp_flag);
        end
      end
      if (o_sw_done === 1'b1) seen = 1;
    end
    i_m_sfp_rsp_valid = 1'b0;
    if (exp_to) m_tcnt++;
    m_sw_rsp = exp_rsp;
    checks++;
    if (!seen || cyc != exp_cyc) begin
      errors++;
      $display("FAIL %s_done_latency: seen=%0d cycles=%0d required %0d", name, seen, cyc, exp_cyc);
    end
    checks++;
    if (o_sw_rsp !== exp_rsp || o_sw_timeout !== exp_to) begin
      errors++;
      $display("FAIL %s_result: rsp=%h to=%b required rsp=%h to=%b", name, o_sw_rsp, o_sw_timeout, exp_rsp, exp_to);
    end
    checks++;
    if (o_timeout_cnt !== 16'(m_tcnt)) begin
      errors++;
      $display("FAIL %s_tcnt: timeout_cnt=%0d required %0d", name, o_timeout_cnt, m_tcnt);
    end
    step();
    checks++;
    if (o_sw_done !== 1'b0 || o_sw_busy !== 1'b0 || o_state !== 3'd0) begin
      errors++;
      $display("FAIL %s_after_done: done=%b busy=%b state=%0d required 0 0 0", name, o_sw_done, o_sw_busy, o_state);
    end
    $display("sw %s id=%0d d=%0d done_after=%0d rsp=%h to=%0b", name, id, d, cyc, o_sw_rsp, o_sw_timeout);
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if (o_state !== 3'd0 || o_sw_busy !== 1'b0 || o_sw_done !== 1'b0 || o_sw_timeout !== 1'b0 ||
        o_m_sfp_flag !== 1'b0 || o_poll_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: state=%0d busy=%b done=%b to=%b flag=%b pv=%b required all 0",
               o_state, o_sw_busy, o_sw_done, o_sw_timeout, o_m_sfp_flag, o_poll_rsp_valid);
    end
    checks++;
    if (o_sw_rsp !== 64'd0 || o_poll_rsp !== 64'd0 || o_poll_id !== 2'd0 || o_sfp_id !== 2'd0 ||
        o_m_sfp_cmd !== 32'd0 || o_m_sfp_data !== 32'd0 || o_timeout_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_data: sw_rsp=%h poll_rsp=%h cmd=%h data=%h tcnt=%0d required all 0",
               o_sw_rsp, o_poll_rsp, o_m_sfp_cmd, o_m_sfp_data, o_timeout_cnt);
    end
    i_rst = 1'b1;
    i_en = 1'b1;
    step();
    $display("reset released");
  endtask

  task automatic test_sw_basic();
    run_sw(2'd2, 32'h0000_0101, 32'h1234_5678, 64'hDEAD_BEEF_0000_0001, 5, "basic");
  endtask

  task automatic test_timeout();
    run_sw(2'($urandom), $urandom, $urandom, {$urandom, $urandom}, 100, "timeout");
    run_sw(2'($urandom), $urandom, $urandom, {$urandom, $urandom}, 3, "after_timeout");
  endtask

  task automatic test_boundary_same_cycle();
    run_sw(2'($urandom), $urandom, $urandom, {$urandom, $urandom}, TO - 1, "rsp_at_expiry");
  endtask

  task automatic test_random_sw();
    for (int n = 0; n < 8; n++) begin
      run_sw(2'($urandom), $urandom, $urandom, {$urandom, $urandom}, $urandom_range(1, 20), "random");
    end
  endtask

  task automatic test_polling();
    int          t = 0;
    int          last = 0;
    int          n = 0;
    int          vcount = 0;
    int          rsp_in = -1;
    int          exp_id = 0;
    logic [63:0] prsp = '0;
    i_poll_mask = 4'b1010;
    i_poll_en = 1'b1;
    while (vcount < 4 && t < 4 * PP + 60) begin
      i_m_sfp_rsp_valid = (rsp_in == 0);
      if (rsp_in >= 0) rsp_in--;
      step();
      t++;
      if (o_m_sfp_flag === 1'b1) begin
        exp_id = model_pick(i_poll_mask, m_ptr);
        m_ptr = (exp_id + 1) % 4;
        checks++;
        if (o_sfp_id !== 2'(exp_id) || o_m_sfp_cmd !== PCMD || o_m_sfp_data !== 32'd0) begin
          errors++;
          $display("FAIL poll_issue: id=%0d cmd=%h data=%h required %0d %h 0", o_sfp_id, o_m_sfp_cmd, o_m_sfp_data, exp_id, PCMD);
        end
        // Timer counts PP cycles, then one IDLE cycle launches the issue.
        checks++;
        if (t - last != ((n == 0) ? PP + 1 : PP)) begin
          errors++;
          $display("FAIL poll_spacing: gap=%0d required %0d", t - last, (n == 0) ? PP + 1 : PP);
        end
        last = t;
        n++;
        prsp = {$urandom, $urandom};
        i_m_sfp_rsp = prsp;
        rsp_in = 1;
      end
      if (o_poll_rsp_valid === 1'b1) begin
        vcount++;
        checks++;
        if (o_poll_id !== 2'(exp_id) || o_poll_rsp !== prsp) begin
          errors++;
          $display("FAIL poll_rsp: id=%0d rsp=%h required %0d %h", o_poll_id, o_poll_rsp, exp_id, prsp);
        end
        $display("poll id=%0d at=%0d rsp=%h", o_poll_id, last, o_poll_rsp);
      end
    end
    i_m_sfp_rsp_valid = 1'b0;
    i_poll_en = 1'b0;
    checks++;
    if (vcount != 4) begin
      errors++;
      $display("FAIL poll_count: responses=%0d required 4", vcount);
    end
    step();
  endtask

  task automatic test_contention();
    logic [3:0]  mask;
    logic [1:0]  sid;
    logic [31:0] scmd;
    logic [63:0] srsp;
    logic [63:0] prsp;
    int          exp_id;
    int          cyc;
    int          flags;
    bit          seen;
    mask = 4'($urandom_range(1, 15));
    sid = 2'($urandom);
    scmd = $urandom;
    srsp = {$urandom, $urandom};
    prsp = {$urandom, $urandom};
    i_poll_mask = mask;
    i_poll_en = 1'b1;
    i_sw_id = sid;
    i_sw_cmd = scmd;
    i_sw_data = $urandom;
    repeat (PP - 1) step();
    i_sw_req_flag = 1'b1;
    step();
    i_poll_en = 1'b0;
    step();
    checks++;
    if (o_m_sfp_flag !== 1'b1 || o_sfp_id !== sid || o_m_sfp_cmd !== scmd) begin
      errors++;
      $display("FAIL contention_sw_first: flag=%b id=%0d cmd=%h required 1 %0d %h", o_m_sfp_flag, o_sfp_id, o_m_sfp_cmd, sid, scmd);
    end
    i_sw_req_flag = 1'b0;
    i_m_sfp_rsp = srsp;
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 40) begin
      i_sw_req_flag = (cyc >= 1);
      i_m_sfp_rsp_valid = (cyc == 3);
      step();
      cyc++;
      if (o_sw_done === 1'b1) seen = 1;
    end
    i_m_sfp_rsp_valid = 1'b0;
    m_sw_rsp = srsp;
    checks++;
    if (!seen || o_sw_rsp !== srsp) begin
      errors++;
      $display("FAIL contention_sw_done: seen=%0d rsp=%h required 1 %h", seen, o_sw_rsp, srsp);
    end
    step();
    checks++;
    if (o_m_sfp_flag !== 1'b0) begin
      errors++;
      $display("FAIL contention_idle_gap: flag=%b required 0", o_m_sfp_flag);
    end
    step();
    exp_id = model_pick(mask, m_ptr);
    m_ptr = (exp_id + 1) % 4;
    checks++;
    if (o_m_sfp_flag !== 1'b1 || o_sfp_id !== 2'(exp_id) || o_m_sfp_cmd !== PCMD) begin
      errors++;
      $display("FAIL contention_poll_next: flag=%b id=%0d cmd=%h required 1 %0d %h", o_m_sfp_flag, o_sfp_id, o_m_sfp_cmd, exp_id, PCMD);
    end
    i_m_sfp_rsp = prsp;
    step();
    i_m_sfp_rsp_valid = 1'b1;
    step();
    i_m_sfp_rsp_valid = 1'b0;
    checks++;
    if (o_poll_rsp_valid !== 1'b1 || o_poll_id !== 2'(exp_id) || o_poll_rsp !== prsp) begin
      errors++;
      $display("FAIL contention_poll_rsp: valid=%b id=%0d rsp=%h required 1 %0d %h", o_poll_rsp_valid, o_poll_id, o_poll_rsp, exp_id, prsp);
    end
    i_sw_req_flag = 1'b0;
    flags = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (o_m_sfp_flag === 1'b1) flags++;
    end
    checks++;
    if (flags != 0 || o_sw_busy !== 1'b0) begin
      errors++;
      $display("FAIL contention_no_extra: flags=%0d busy=%b required 0 0", flags, o_sw_busy);
    end
    $display("contention sw_id=%0d then poll_id=%0d mask=%b", sid, exp_id, mask);
  endtask

  task automatic test_abort();
    logic [31:0] cmd;
    logic [15:0] tcnt_before;
    int          flags;
    cmd = $urandom;
    tcnt_before = o_timeout_cnt;
    i_sw_id = 2'($urandom);
    i_sw_cmd = cmd;
    i_sw_data = $urandom;
    i_sw_req_flag = 1'b1;
    step();
    step();
    i_sw_req_flag = 1'b0;
    repeat (4) step();
    i_en = 1'b0;
    step();
    checks++;
    if (o_state !== 3'd0 || o_sw_busy !== 1'b0 || o_sw_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: state=%0d busy=%b done=%b required 0 0 0", o_state, o_sw_busy, o_sw_done);
    end
    i_m_sfp_rsp = {$urandom, $urandom};
    i_m_sfp_rsp_valid = 1'b1;
    step();
    i_m_sfp_rsp_valid = 1'b0;
    checks++;
    if (o_sw_done !== 1'b0 || o_sw_rsp !== m_sw_rsp || o_m_sfp_cmd !== cmd || o_timeout_cnt !== tcnt_before) begin
      errors++;
      $display("FAIL abort_late_rsp: done=%b rsp=%h cmd=%h tcnt=%0d required 0 %h %h %0d",
               o_sw_done, o_sw_rsp, o_m_sfp_cmd, o_timeout_cnt, m_sw_rsp, cmd, tcnt_before);
    end
    i_en = 1'b1;
    flags = 0;
    for (int k = 0; k < 6; k++) begin
      i_m_sfp_rsp_valid = (k == 2);
      step();
      if (o_m_sfp_flag === 1'b1 || o_sw_done === 1'b1 || o_poll_rsp_valid === 1'b1) flags++;
    end
    i_m_sfp_rsp_valid = 1'b0;
    checks++;
    if (flags != 0 || o_state !== 3'd0) begin
      errors++;
      $display("FAIL abort_quiet: events=%0d state=%0d required 0 0", flags, o_state);
    end
    $display("abort cmd=%h state=%0d busy=%b", cmd, o_state, o_sw_busy);
  endtask

  task automatic test_mask_zero();
    logic [63:0] srsp;
    int          cyc;
    int          flags;
    bit          seen;
    srsp = {$urandom, $urandom};
    i_poll_mask = 4'($urandom_range(1, 15));
    i_poll_en = 1'b1;
    i_sw_id = 2'($urandom);
    i_sw_cmd = $urandom;
    i_sw_data = $urandom;
    repeat (40) step();
    i_sw_req_flag = 1'b1;
    step();
    step();
    i_sw_req_flag = 1'b0;
    i_m_sfp_rsp = srsp;
    cyc = 0;
    seen = 0;
    // The poll tick lands while the software transaction is still waiting.
    while (!seen && cyc < 40) begin
      if (cyc == 10) i_poll_mask = 4'b0000;
      i_m_sfp_rsp_valid = (cyc == 13);
      step();
      cyc++;
      if (o_sw_done === 1'b1) seen = 1;
    end
    i_m_sfp_rsp_valid = 1'b0;
    m_sw_rsp = srsp;
    checks++;
    if (!seen || o_sw_rsp !== srsp || cyc != 14) begin
      errors++;
      $display("FAIL mask0_sw: seen=%0d cycles=%0d rsp=%h required 1 14 %h", seen, cyc, o_sw_rsp, srsp);
    end
    flags = 0;
    repeat (3) begin
      step();
      if (o_m_sfp_flag === 1'b1) flags++;
    end
    i_poll_mask = 4'b1111;
    for (int k = 0; k < 30; k++) begin
      step();
      if (o_m_sfp_flag === 1'b1) flags++;
    end
    i_poll_en = 1'b0;
    checks++;
    if (flags != 0) begin
      errors++;
      $display("FAIL mask0_pend_cleared: flags=%0d required 0", flags);
    end
    step();
    $display("mask_zero pend dropped, flags=%0d", flags);
  endtask

  initial begin
    test_reset();
    test_sw_basic();
    test_timeout();
    test_boundary_same_cycle();
    test_random_sw();
    test_polling();
    test_contention();
    test_abort();
    test_mask_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
